register_bank_param: RTL
========================

# register_bank_param

Parametrised register bank for the FPGA processor datapath, generalising the fixed PC/AC/RA–RC/R1–R3/DR/AR/IR register unit to NUM_REGS data registers. Per-register features:

- Write from the C bus.
- Selectable increment/decrement.
- Single-read mux onto the B bus.

The data register (DR) is loaded from RAM through a request/acknowledge read FSM with timeout. The address register (AR) drives the RAM address. The bank sits between the control unit, which drives all enables, selects and starts, and the ALU/RAM.

## Interface

Parameters:

- DATA_W, 16, register and bus width
- NUM_REGS, 10, number of bank registers, indices 0..NUM_REGS-1; index 0 is AC
- SEL_W, 4, B-bus select width; requires 2^SEL_W ≥ NUM_REGS
- INC_MASK, 10'b0111000001, bit i set = register i supports inc/dec
- DR_IDX, 2, index of the data register
- AR_IDX, 1, index of the address register
- MAX_WAIT, 8, RAM-read timeout in cycles (≥2)

Ports:

- Reset is synchronous and active-high.
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous active-high reset
- c_bus_in  in  DATA_W  C-bus write data
- c_we  in  NUM_REGS  per-register write enable; multi-hot writes all flagged registers
- inc  in  NUM_REGS  per-register increment
- dec  in  NUM_REGS  per-register decrement (present only with REGBANK_DEC_EN)
- b_sel  in  SEL_W  B-bus source index
- b_bus_out  out  DATA_W  combinational mux of register[b_sel]; 0 if b_sel ≥ NUM_REGS
- ac_out  out  DATA_W  register 0, direct
- ld_ir  in  1  load IR from DR
- ir_out  out  DATA_W  instruction register
- mem_rd_start  in  1  begin RAM read at current AR
- mem_req  out  1  registered read request
- mem_addr  out  DATA_W  address latched at start
- mem_rdata  in  DATA_W  RAM read data, valid with mem_ack
- mem_ack  in  1  RAM acknowledge
- rd_busy  out  1  FSM not IDLE
- rd_done  out  1  one-cycle pulse: DR loaded
- rd_err  out  1  one-cycle pulse: timeout, DR unchanged

## Operation

- Per-register update priority: rst > RAM load (DR only) > c_we > inc > dec > hold.
- inc/dec on registers with INC_MASK bit clear are ignored.
- inc and dec wrap modulo 2^DATA_W.
- inc and dec asserted together on one register: inc wins.
- ld_ir copies the DR value present before the edge. It is independent of the DR update in the same cycle.
- Read FSM states IDLE and WAIT:
  - IDLE→WAIT on mem_rd_start. mem_addr latches AR, wait counter clears.
  - mem_rd_start while in WAIT is ignored.
  - In WAIT with mem_ack=1: DR←mem_rdata, FSM→IDLE, rd_done pulses.
  - In WAIT with no ack and counter = MAX_WAIT-1: FSM→IDLE, rd_err pulses.
  - Ack and timeout in the same cycle: ack wins.
- Writes to AR during WAIT do not change mem_addr.
- c_we to DR in the same cycle as mem_ack: the RAM data is stored.
- mem_ack in IDLE is ignored.

## Timing

- The following reset to 0: all registers, ir_out, mem_addr, mem_req, rd_busy, rd_done and rd_err. The FSM resets to IDLE.
- Register writes, inc and dec take effect at the edge and are visible on b_bus_out and ac_out in the following cycle.
- mem_rd_start sampled at edge t: mem_req and rd_busy are high from t through the ack edge.
- mem_ack sampled at edge k: DR is updated and rd_done is high in cycle k+1, and mem_req drops in cycle k+1.
- Minimum read latency from start to rd_done is 2 cycles.
- rst during WAIT: mem_req drops in the next cycle. No rd_done or rd_err is produced, and the ack is discarded.

## Configuration

- REGBANK_DEC_EN defined: the dec port exists and decrement is active per INC_MASK.
- REGBANK_DEC_EN undefined: the dec port is removed and registers support only write and inc.

## Structure

- regbank_pkg holds:
  - the read-FSM state enum {RD_IDLE, RD_WAIT}
  - default width constants
  - AC_IDX = 0
- Sub-module regbank_cell: one DATA_W register with HAS_INC parameter and write/inc/dec priority. It is instantiated NUM_REGS times via generate.

## Test plan

- Reset, then c_we[5]=1 with c_bus_in=16'h1234, then b_sel=5 → b_bus_out=16'h1234 one cycle later; b_sel=12 → 0.
- AC=16'hFFFF with inc[0] → AC=16'h0000. inc[3] (mask clear) on R=16'h0007 → unchanged.
- c_we[0] and inc[0] in the same cycle with c_bus_in=16'h0010 → AC=16'h0010.
- AR=16'h0040, mem_rd_start, then write AR=16'h0099; ack after 3 cycles with rdata=16'hBEEF → mem_addr stays 16'h0040, DR=16'hBEEF, one-cycle rd_done; then ld_ir → ir_out=16'hBEEF.
- mem_rd_start with no ack for 8 cycles → one-cycle rd_err, DR unchanged, mem_req low. A later ack is ignored.
- rst asserted during WAIT → mem_req=0 and rd_busy=0 next cycle, no rd_done or rd_err pulse.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the parametrised register bank.
// Decrement support is compiled in only when REGBANK_DEC_EN is defined.
package regbank_pkg;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_WAIT = 1'b1
   } rd_state_t;

   localparam int DEFAULT_DATA_W   = 16;
   localparam int DEFAULT_NUM_REGS = 10;
   localparam int DEFAULT_SEL_W    = 4;
   localparam int DEFAULT_DR_IDX   = 2;
   localparam int DEFAULT_AR_IDX   = 1;
   localparam int DEFAULT_MAX_WAIT = 8;
   localparam logic [DEFAULT_NUM_REGS-1:0] DEFAULT_INC_MASK = 10'b0111000001;

   localparam int AC_IDX = 0;

endpackage

// File: rtl/regbank_cell.sv
// One bank register: priority is rst > external load > write > inc > dec > hold.
// inc/dec only act when HAS_INC is set; the bank ties dec low unless REGBANK_DEC_EN.
module regbank_cell #(
   parameter int DATA_W  = 16,
   parameter bit HAS_INC = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              inc,
   input  logic              dec,
   output logic [DATA_W-1:0] q
);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (we) begin
         q <= wdata;
      end else if (HAS_INC && inc) begin
         q <= q + DATA_W'(1);
      end else if (HAS_INC && dec) begin
         q <= q - DATA_W'(1);
      end
   end

endmodule

// File: rtl/register_bank_param.sv
// NUM_REGS-entry register bank with B-bus read mux, IR, and a RAM read FSM
// that loads DR with timeout. The dec port exists only when REGBANK_DEC_EN is defined.
module register_bank_param
   import regbank_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int SEL_W    = DEFAULT_SEL_W,
   parameter logic [NUM_REGS-1:0] INC_MASK = DEFAULT_INC_MASK,
   parameter int DR_IDX   = DEFAULT_DR_IDX,
   parameter int AR_IDX   = DEFAULT_AR_IDX,
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   c_bus_in,
   input  logic [NUM_REGS-1:0] c_we,
   input  logic [NUM_REGS-1:0] inc,
`ifdef REGBANK_DEC_EN
   input  logic [NUM_REGS-1:0] dec,
`endif
   input  logic [SEL_W-1:0]    b_sel,
   output logic [DATA_W-1:0]   b_bus_out,
   output logic [DATA_W-1:0]   ac_out,
   input  logic                ld_ir,
   output logic [DATA_W-1:0]   ir_out,
   input  logic                mem_rd_start,
   output logic                mem_req,
   output logic [DATA_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack,
   output logic                rd_busy,
   output logic                rd_done,
   output logic                rd_err
);

   localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] dec_eff;
   logic                ram_load;
   rd_state_t           state;
   logic [CNT_W-1:0]    wait_cnt;

`ifdef REGBANK_DEC_EN
   assign dec_eff = dec;
`else
   assign dec_eff = '0;
`endif

   // An ack is only meaningful while a read is outstanding.
   assign ram_load = (state == RD_WAIT) && mem_ack;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      regbank_cell #(
         .DATA_W  (DATA_W),
         .HAS_INC (INC_MASK[g])
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .load      ((g == DR_IDX) ? ram_load : 1'b0),
         .load_data (mem_rdata),
         .we        (c_we[g]),
         .wdata     (c_bus_in),
         .inc       (inc[g]),
         .dec       (dec_eff[g]),
         .q         (regs[g])
      );
   end

   assign ac_out = regs[AC_IDX];

   // NOTE: the default before the loop keeps this purely combinational (no latch).
   always_comb begin
      b_bus_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (b_sel == SEL_W'(i)) begin
            b_bus_out = regs[i];
         end
      end
   end

   // IR takes the DR value from before the edge, regardless of a concurrent DR load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_out <= '0;
      end else if (ld_ir) begin
         ir_out <= regs[DR_IDX];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RD_IDLE;
         wait_cnt <= '0;
         mem_req  <= 1'b0;
         rd_busy  <= 1'b0;
         rd_done  <= 1'b0;
         rd_err   <= 1'b0;
         mem_addr <= '0;
      end else begin
         rd_done <= 1'b0;
         rd_err  <= 1'b0;
         case (state)
            RD_IDLE: begin
               if (mem_rd_start) begin
                  state    <= RD_WAIT;
                  wait_cnt <= '0;
                  mem_req  <= 1'b1;
                  rd_busy  <= 1'b1;
                  mem_addr <= regs[AR_IDX];
               end
            end
            RD_WAIT: begin
               if (mem_ack) begin
                  state   <= RD_IDLE;
                  mem_req <= 1'b0;
                  rd_busy <= 1'b0;
                  rd_done <= 1'b1;
               end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                  state   <= RD_IDLE;
                  mem_req <= 1'b0;
                  rd_busy <= 1'b0;
                  rd_err  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= RD_IDLE;
               mem_req <= 1'b0;
               rd_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
